vga_sync_gen: RTL and testbench

Upstream timing stage for every pixel-drawing block in the design. It generates 640x480@60 VGA raster timing from the single pixel-rate clock, producing hpos, vpos, display_on, hsync and vsync for downstream renderers. It also produces single-cycle frame_start and vblank_start strobes, so downstream logic advances per frame on clk with an enable rather than clocking on vsync edges.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_sync_gen.sv | 88 ++++++++
 tb/tb_vga_sync_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and sync-level helper.
// Downstream renderers import this package for screen bounds.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam bit          VGA_SYNC_ACTIVE = 1'b0;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    function automatic logic sync_level(input logic active, input logic pulse);
        return pulse ? active : ~active;
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters, sync decode and per-frame strobes.
// Optional frame_count output is enabled by defining VGA_FRAME_COUNT_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY   = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_DISPLAY   = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter bit          SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic             display_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start,
`ifdef VGA_FRAME_COUNT_EN
    output logic             vblank_start,
    output logic [7:0]       frame_count
`else
    output logic             vblank_start
`endif
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic             h_wrap;
    logic [CNT_W-1:0] next_h;
    logic [CNT_W-1:0] next_v;

    always_comb begin
        h_wrap = (hpos == H_LAST);
        next_h = h_wrap ? '0 : hpos + CNT_W'(1);
        next_v = vpos;
        if (h_wrap) begin
            next_v = (vpos == V_LAST) ? '0 : vpos + CNT_W'(1);
        end
    end

    // Decode from next_h/next_v so registered outputs line up with the registered counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos         <= H_LAST;
            vpos         <= V_LAST;
            display_on   <= 1'b0;
            hsync        <= sync_level(SYNC_ACTIVE, 1'b0);
            vsync        <= sync_level(SYNC_ACTIVE, 1'b0);
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            hpos         <= next_h;
            vpos         <= next_v;
            display_on   <= (next_h < H_ACT) && (next_v < V_ACT);
            hsync        <= sync_level(SYNC_ACTIVE, (next_h >= HS_START) && (next_h <= HS_END));
            vsync        <= sync_level(SYNC_ACTIVE, (next_v >= VS_START) && (next_v <= VS_END));
            frame_start  <= (next_h == '0) && (next_v == '0);
            vblank_start <= (next_h == '0) && (next_v == V_ACT);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if ((next_h == '0) && (next_v == '0)) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: full-size and reduced-geometry instances
// checked against an arithmetic raster model every cycle, plus directed vectors.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       disp;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       vbs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int   rst_cyc;
        int   run_cyc;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, rst_s;
    logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic       d_disp, d_hs, d_vs, d_fs, d_vbs;
    logic       s_disp, s_hs, s_vs, s_fs, s_vbs;
    logic [7:0] d_fc, s_fc;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    longint st_d = -1;
    longint st_s = -1;

    vga_sync_gen u_dflt (
        .clk          (clk),
        .reset        (rst_d),
        .hpos         (d_hpos),
        .vpos         (d_vpos),
        .display_on   (d_disp),
        .hsync        (d_hs),
        .vsync        (d_vs),
        .frame_start  (d_fs),
`ifdef VGA_FRAME_COUNT_EN
        .vblank_start (d_vbs),
        .frame_count  (d_fc)
`else
        .vblank_start (d_vbs)
`endif
    );

    // Reduced geometry (16 x 10, active-high syncs) so whole frames fit the cycle budget.
    vga_sync_gen #(
        .H_DISPLAY   (8),
        .H_FRONT     (2),
        .H_SYNC      (3),
        .H_BACK      (3),
        .V_DISPLAY   (5),
        .V_FRONT     (1),
        .V_SYNC      (2),
        .V_BACK      (2),
        .SYNC_ACTIVE (1'b1)
    ) u_small (
        .clk          (clk),
        .reset        (rst_s),
        .hpos         (s_hpos),
        .vpos         (s_vpos),
        .display_on   (s_disp),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .frame_start  (s_fs),
`ifdef VGA_FRAME_COUNT_EN
        .vblank_start (s_vbs),
        .frame_count  (s_fc)
`else
        .vblank_start (s_vbs)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign d_fc = 8'd0;
    assign s_fc = 8'd0;
`endif

    // Raster model: st is the number of non-reset edges since reset released, minus one.
    function automatic obs_t ref_model(longint st, longint hd, longint hf, longint hsw, longint hb,
                                       longint vd, longint vf, longint vsw, longint vb, bit act);
        obs_t   r;
        longint ht, vt, frame, pos, h, v;
        ht    = hd + hf + hsw + hb;
        vt    = vd + vf + vsw + vb;
        frame = ht * vt;
        r.fc  = 8'd0;
        if (st < 0) begin
            r.hpos = 10'(ht - 1);
            r.vpos = 10'(vt - 1);
            r.disp = 1'b0;
            r.hs   = ~act;
            r.vs   = ~act;
            r.fs   = 1'b0;
            r.vbs  = 1'b0;
        end else begin
            pos    = st % frame;
            h      = pos % ht;
            v      = pos / ht;
            r.hpos = 10'(h);
            r.vpos = 10'(v);
            r.disp = (h < hd) && (v < vd);
            r.hs   = ((h >= hd + hf) && (h < hd + hf + hsw)) ? act : ~act;
            r.vs   = ((v >= vd + vf) && (v < vd + vf + vsw)) ? act : ~act;
            r.fs   = (pos == 0);
            r.vbs  = (pos == vd * ht);
`ifdef VGA_FRAME_COUNT_EN
            r.fc   = 8'((st / frame + 1) % 256);
`endif
        end
        return r;
    endfunction

    function automatic obs_t obs_d();
        return '{hpos: d_hpos, vpos: d_vpos, disp: d_disp, hs: d_hs, vs: d_vs,
                 fs: d_fs, vbs: d_vbs, fc: d_fc};
    endfunction

    function automatic obs_t obs_s();
        return '{hpos: s_hpos, vpos: s_vpos, disp: s_disp, hs: s_hs, vs: s_vs,
                 fs: s_fs, vbs: s_vbs, fc: s_fc};
    endfunction

    task automatic cmp(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got h=%0d v=%0d disp=%b hs=%b vs=%b fs=%b vbs=%b fc=%0d, expected h=%0d v=%0d disp=%b hs=%b vs=%b fs=%b vbs=%b fc=%0d",
                     name, $time, got.hpos, got.vpos, got.disp, got.hs, got.vs, got.fs, got.vbs, got.fc,
                     exp.hpos, exp.vpos, exp.disp, exp.hs, exp.vs, exp.fs, exp.vbs, exp.fc);
        end
    endtask

    task automatic cmp_int(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        st_d <= rst_d ? -1 : st_d + 1;
        st_s <= rst_s ? -1 : st_s + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            cmp("model_dflt", obs_d(), ref_model(st_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            cmp("model_small", obs_s(), ref_model(st_s, 8, 2, 3, 3, 5, 1, 2, 2, 1'b1));
        end
    end

    task automatic wait_small_fs(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (s_fs === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) cmp_int({name, "_timeout"}, 0, 1);
    endtask

    vec_t vecs[12];
    obs_t e;
    bit   ok;
    int   cnt, vb_at, hs_cnt, vs_cnt;

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // {reset cycles, run cycles, expected outputs} on the full-size instance (active-low syncs)
        vecs[0]  = '{2, 0,    '{10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[1]  = '{1, 1,    '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}};
        vecs[2]  = '{1, 2,    '{10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[3]  = '{1, 640,  '{10'd639, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[4]  = '{1, 641,  '{10'd640, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[5]  = '{1, 656,  '{10'd655, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[6]  = '{1, 657,  '{10'd656, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[7]  = '{1, 752,  '{10'd751, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[8]  = '{1, 753,  '{10'd752, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[9]  = '{1, 800,  '{10'd799, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[10] = '{1, 801,  '{10'd0,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[11] = '{1, 1601, '{10'd0,   10'd2,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};

        foreach (vecs[i]) begin
            rst_d = 1'b1;
            repeat (vecs[i].rst_cyc) @(negedge clk);
            rst_d = 1'b0;
            repeat (vecs[i].run_cyc) @(negedge clk);
            e = vecs[i].exp;
`ifdef VGA_FRAME_COUNT_EN
            e.fc = (vecs[i].run_cyc > 0) ? 8'd1 : 8'd0;
`endif
            cmp($sformatf("vec%0d", i), obs_d(), e);
        end

        // Reset held for 10 cycles: reset values every cycle, no strobes.
        rst_d = 1'b1;
        e = '{10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp("reset_hold", obs_d(), e);
        end
        rst_d = 1'b0;

        // Small instance: frame period, vblank offset, sync pulse widths.
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        wait_small_fs("first_fs", ok);
        if (ok) begin
            cnt = 0; vb_at = -1; hs_cnt = 0; vs_cnt = 0;
            while (cnt < 1000) begin
                @(negedge clk);
                cnt++;
                if (s_vbs === 1'b1) vb_at = cnt;
                if (s_hs === 1'b1) hs_cnt++;
                if (s_vs === 1'b1) vs_cnt++;
                if (s_fs === 1'b1) break;
            end
            cmp_int("frame_period", cnt, 160);
            cmp_int("vblank_offset", vb_at, 80);
            cmp_int("hsync_cycles", hs_cnt, 30);
            cmp_int("vsync_cycles", vs_cnt, 32);
        end

        // Mid-frame reset at h=5, v=3, then restart exactly as after power-on.
        cnt = 0;
        while (!(s_hpos == 10'd5 && s_vpos == 10'd3) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        cmp_int("reach_5_3", (cnt < 400) ? 1 : 0, 1);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        cmp("midframe_reset", obs_s(), '{10'd15, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        @(negedge clk);
        e = '{10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
`ifdef VGA_FRAME_COUNT_EN
        e.fc = 8'd1;
`endif
        cmp("restart", obs_s(), e);

        // Randomized reset pulses; the per-cycle model check covers every cycle.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            rst_s = 1'b1;
            if ($urandom_range(0, 3) == 0) rst_d = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_s = 1'b0;
            rst_d = 1'b0;
        end

`ifdef VGA_FRAME_COUNT_EN
        // frame_count over 257 frames, including the 255 -> 0 wrap.
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        for (int f = 1; f <= 257; f++) begin
            wait_small_fs($sformatf("fc_fs%0d", f), ok);
            if (!ok) break;
            cmp_int($sformatf("frame_count%0d", f), longint'(s_fc), longint'(f % 256));
            @(negedge clk);
        end
`endif

        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
